// File: rtl/rbuf_reader.sv
// Consumer-side ring-buffer reader: mirrors occupancy, paces reads on tick, presents words on valid/ready.
// Optional transfer counter port xfer_cnt is enabled by defining RDR_STATS_EN.
module rbuf_reader #(
   parameter int WORDLEN = 8,
   parameter int BUFSIZE = 16,
   parameter int CNTW    = 5
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               wr_seen,
   input  logic               tick,
   output logic               rd,
   input  logic [WORDLEN-1:0] buf_dout,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [WORDLEN-1:0] m_data,
   output logic [CNTW-1:0]    occ,
   output logic               empty,
   output logic               full,
`ifdef RDR_STATS_EN
   output logic               overflow,
   output logic [15:0]        xfer_cnt
`else
   output logic               overflow
`endif
);

   localparam logic [CNTW-1:0] FULL_OCC = CNTW'(BUFSIZE);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CNTW-1:0]    r_occ;
   logic               r_ovf;
   logic               r_valid;
   logic [WORDLEN-1:0] r_data;
   logic               w_rd;
   logic               w_load;
   logic               w_drop;
   logic               w_accept;
   logic               w_avail;
   logic               w_full;

   assign w_accept = r_valid & m_ready;
   assign w_avail  = (r_occ != '0);
   assign w_full   = (r_occ == FULL_OCC);

   always_ff @(posedge clk) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // rd is forced low while reset is asserted so no read leaks out during reset
   always_comb begin
      w_next = r_state;
      w_rd   = 1'b0;
      w_load = 1'b0;
      w_drop = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (tick && w_avail) begin
               w_rd   = 1'b1;
               w_next = S_WAIT;
            end
         end
         S_WAIT: begin
            w_load = 1'b1;
            w_next = S_HOLD;
         end
         S_HOLD: begin
            if (w_accept) begin
               w_drop = 1'b1;
               if (tick && w_avail) begin
                  w_rd   = 1'b1;
                  w_next = S_WAIT;
               end else begin
                  w_next = S_IDLE;
               end
            end
         end
         default: w_next = S_IDLE;
      endcase
      if (!rstn) w_rd = 1'b0;
   end

   // Simultaneous write and read cancel; a write into a full buffer is lost and flagged
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_occ <= '0;
         r_ovf <= 1'b0;
      end else begin
         case ({wr_seen, w_rd})
            2'b10: begin
               if (w_full) r_ovf <= 1'b1;
               else        r_occ <= r_occ + CNTW'(1);
            end
            2'b01:   r_occ <= r_occ - CNTW'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_data  <= buf_dout;
      end else if (w_drop) begin
         r_valid <= 1'b0;
      end
   end

`ifdef RDR_STATS_EN
   logic [15:0] r_xfer;

   always_ff @(posedge clk) begin
      if (!rstn)         r_xfer <= '0;
      else if (w_accept) r_xfer <= r_xfer + 16'd1;
   end

   assign xfer_cnt = r_xfer;
`endif

   assign rd       = w_rd;
   assign m_valid  = r_valid;
   assign m_data   = r_data;
   assign occ      = r_occ;
   assign empty    = ~w_avail;
   assign full     = w_full;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_rbuf_reader.sv
// Bench for rbuf_reader: the bench plays the ring buffer and checks the reader against a transaction model.
module tb_rbuf_reader;
   localparam int WL = 8;
   localparam int BS = 16;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          wr_seen = 1'b0;
   logic          tick = 1'b0;
   logic          rd;
   logic [WL-1:0] buf_dout = '0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [WL-1:0] m_data;
   logic [CW-1:0] occ;
   logic          empty;
   logic          full;
   logic          overflow;
`ifdef RDR_STATS_EN
   logic [15:0]   xfer_cnt;
`endif

   always #5 clk = ~clk;

   rbuf_reader #(.WORDLEN(WL), .BUFSIZE(BS), .CNTW(CW)) dut (
      .clk(clk), .rstn(rstn), .wr_seen(wr_seen), .tick(tick), .rd(rd),
      .buf_dout(buf_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .occ(occ), .empty(empty), .full(full),
`ifdef RDR_STATS_EN
      .overflow(overflow), .xfer_cnt(xfer_cnt)
`else
      .overflow(overflow)
`endif
   );

   int total = 0;
   int bad = 0;

   // Transaction model: buffer contents, mirrored count, one word in flight, one word held
   int            occ_m = 0;
   bit            ovf_m = 0;
   logic [WL-1:0] bufq[$];
   bit            pend_m = 0;
   bit            hold_m = 0;
   logic [WL-1:0] pend_w = '0;
   logic [WL-1:0] data_m = '0;
   int            cnt_m = 0;

   bit            rd_now;
   bit            acc_now;
   logic [WL-1:0] dut_acc[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input bit w, input logic [WL-1:0] d, input bit t, input bit r, input bit rs);
      bit            rde;
      bit            acc;
      int            on;
      logic [WL-1:0] popped;
      popped = '0;
      @(negedge clk);
      wr_seen = w; tick = t; m_ready = r; rstn = rs;
      #1;
      rde = rs && t && (occ_m > 0) && !pend_m && (!hold_m || r);
      chk("rd", rd, rde);
      chk("m_valid", m_valid, hold_m);
      chk("m_data", m_data, data_m);
      chk("occ", occ, occ_m);
      chk("empty", empty, occ_m == 0);
      chk("full", full, occ_m == BS);
      chk("overflow", overflow, ovf_m);
`ifdef RDR_STATS_EN
      chk("xfer_cnt", xfer_cnt, cnt_m);
`endif
      rd_now  = rd;
      acc_now = m_valid && m_ready;
      if (acc_now && rs) dut_acc.push_back(m_data);
      if (!rs) begin
         occ_m = 0; ovf_m = 0; bufq.delete();
         pend_m = 0; hold_m = 0; data_m = '0; cnt_m = 0;
      end else begin
         acc = hold_m && r;
         on  = occ_m;
         if (w && !rde) begin
            if (on == BS) ovf_m = 1;
            else          occ_m++;
         end else if (rde && !w) begin
            occ_m--;
         end
         if (rde) popped = bufq.pop_front();
         if (w && (on < BS || rde)) bufq.push_back(d);
         if (pend_m) begin
            data_m = pend_w;
            hold_m = 1;
         end else if (acc) begin
            hold_m = 0;
            cnt_m  = (cnt_m + 1) & 16'hFFFF;
         end
         pend_m = rde;
         if (rde) pend_w = popped;
      end
      @(posedge clk);
      #1;
      if (rde) buf_dout = popped;
   endtask

   initial begin
      int nrd, nacc, bad_tick;
      int rdpos[$];
      logic [WL-1:0] w5[4];

      // Scenario 1: three writes, drained at full tick rate
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("rst_occ", occ, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_empty", empty, 1);
`ifdef RDR_STATS_EN
      chk("rst_xfer", xfer_cnt, 0);
`endif
      nrd = 0; nacc = 0;
      for (int i = 0; i < 13; i++) begin
         cyc(i < 3, 8'h10 + 8'(i), 1, 1, 1);
         if (rd_now) begin nrd++; rdpos.push_back(i); end
         if (acc_now) nacc++;
      end
      chk("t1_nrd", nrd, 3);
      chk("t1_nacc", nacc, 3);
      chk("t1_occ", occ, 0);
      chk("t1_empty", empty, 1);
      if (rdpos.size() == 3) begin
         chk("t1_gap0", rdpos[1] - rdpos[0], 2);
         chk("t1_gap1", rdpos[2] - rdpos[1], 2);
      end
      chk("t1_words", dut_acc.size(), 3);

      // Scenario 2: held word under backpressure
      cyc(1, 8'hA5, 1, 0, 1);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 1, 0, 1);
         if (i >= 1) begin
            chk("t2_valid", m_valid, 1);
            chk("t2_data", m_data, 8'hA5);
         end
      end
      cyc(0, 0, 0, 1, 1);
      chk("t2_accept", acc_now, 1);
      chk("t2_valid_after", m_valid, 0);

      // Scenario 3: overfill sets sticky overflow
      for (int i = 0; i < 17; i++) cyc(1, 8'(i), 0, 0, 1);
      chk("t3_occ", occ, 16);
      chk("t3_full", full, 1);
      chk("t3_ovf", overflow, 1);
      for (int i = 0; i < 40; i++) cyc(0, 0, 1, 1, 1);
      chk("t3_ovf_kept", overflow, 1);
      chk("t3_empty", empty, 1);

      // Scenario 4: write and read in the same cycle
      for (int i = 0; i < 4; i++) cyc(1, 8'h40 + 8'(i), 0, 0, 1);
      cyc(1, 8'h44, 1, 1, 1);
      chk("t4_rd", rd_now, 1);
      chk("t4_occ", occ, 4);
      for (int i = 0; i < 20; i++) cyc(0, 0, 1, 1, 1);

      // Scenario 5: sparse ticks, order preserved
      w5[0] = 8'h11; w5[1] = 8'h22; w5[2] = 8'h33; w5[3] = 8'h44;
      dut_acc.delete();
      for (int i = 0; i < 4; i++) cyc(1, w5[i], 0, 0, 1);
      bad_tick = 0;
      for (int i = 0; i < 48; i++) begin
         cyc(0, 0, (i % 8) == 0, 1, 1);
         if (rd_now && (i % 8) != 0) bad_tick++;
      end
      chk("t5_rd_off_tick", bad_tick, 0);
      chk("t5_count", dut_acc.size(), 4);
      if (dut_acc.size() == 4)
         for (int i = 0; i < 4; i++) chk("t5_order", dut_acc[i], w5[i]);

      // Scenario 6: reset during the wait cycle
      cyc(1, 8'h5A, 0, 1, 1);
      cyc(0, 0, 1, 1, 1);
      chk("t6_rd", rd_now, 1);
      cyc(0, 0, 0, 1, 0);
      chk("t6_valid", m_valid, 0);
      chk("t6_occ", occ, 0);
`ifdef RDR_STATS_EN
      chk("t6_xfer", xfer_cnt, 0);
`endif
      cyc(0, 0, 1, 1, 1);
      chk("t6_still_idle", m_valid, 0);

      // Random traffic with occasional resets
      for (int i = 0; i < 4000; i++) begin
         cyc($urandom_range(0, 99) < 40, 8'($urandom), $urandom_range(0, 1) == 1,
             $urandom_range(0, 99) < 60, $urandom_range(0, 499) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
